// File: rtl/cpu_clken.sv
// Z80 clock-enable generator with ULA beam counters, contention stretching and frame interrupt.
// Contended slots suppress cep/cen; turbo modes shorten the enable period and bypass contention.
module cpu_clken #(
    parameter int DIV     = 8,
    parameter int LINE_T  = 228,
    parameter int LINES   = 311,
    parameter int CONT_V0 = 63,
    parameter int CONT_H0 = 0,
    parameter int INT_V   = 0,
    parameter int INT_H   = 3,
    parameter int INT_LEN = 36
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] turbo,
    input  logic       cn_req,
    output logic       cep,
    output logic       cen,
    output logic       int_n,
    output logic [7:0] hcount,
    output logic [8:0] vcount,
    output logic       hold
);

    localparam int PW = $clog2(DIV);

    logic [PW-1:0] phase;
    logic [1:0]    tq;
    logic [1:0]    tq_next;
    logic [7:0]    h_next;
    logic [8:0]    v_next;
    logic [7:0]    icnt;
    logic          slot_end;
    logic [PW-1:0] pmask;
    logic [PW-1:0] phalf;

    function automatic logic contended(input logic [7:0] h, input logic [8:0] v);
        int hr;
        int vi;
        hr = int'(h) - CONT_H0;
        vi = int'(v);
        return (vi >= CONT_V0) && (vi < CONT_V0 + 192) &&
               (hr >= 0) && (hr < 128) && ((hr & 7) < 6);
    endfunction

    always_comb begin
        slot_end = (phase == PW'(DIV - 1));
        tq_next  = (turbo == 2'b11) ? 2'b10 : turbo;
        h_next   = (hcount == 8'(LINE_T - 1)) ? 8'd0 : hcount + 8'd1;
        v_next   = vcount;
        if (hcount == 8'(LINE_T - 1))
            v_next = (vcount == 9'(LINES - 1)) ? 9'd0 : vcount + 9'd1;
        // Enable period P = DIV >> tq; tq never exceeds 2, so P >= 2.
        pmask = PW'((DIV >> tq) - 1);
        phalf = PW'((DIV >> tq) / 2);
        cep   = !hold && ((phase & pmask) == '0);
        cen   = !hold && ((phase & pmask) == phalf);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase  <= '0;
            tq     <= 2'b00;
            hcount <= 8'd0;
            vcount <= 9'd0;
            hold   <= 1'b0;
            icnt   <= 8'd0;
            int_n  <= 1'b1;
        end else begin
            phase <= phase + PW'(1);
            if (slot_end) begin
                tq     <= tq_next;
                hcount <= h_next;
                vcount <= v_next;
                hold   <= cn_req && (tq_next == 2'b00) && contended(h_next, v_next);
                // A fresh start position reloads the length even mid-interrupt.
                if (h_next == 8'(INT_H) && v_next == 9'(INT_V)) begin
                    icnt  <= 8'(INT_LEN);
                    int_n <= 1'b0;
                end else if (icnt != 8'd0) begin
                    icnt <= icnt - 8'd1;
                    if (icnt == 8'd1)
                        int_n <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_clken.sv
// Directed bench for cpu_clken using a shrunk frame (136 T-states x 12 lines) so whole frames fit in a short run.
// Expected beam position, interrupt and contention are derived from clocks elapsed since reset release.
module tb_cpu_clken;

    localparam int LT  = 136;
    localparam int NL  = 12;
    localparam int FR  = LT * NL;
    localparam int IS  = 10 * LT + 130;
    localparam int ILN = 36;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] turbo = 2'b00;
    logic       cn_req = 1'b0;
    logic       cep, cen, int_n, hold;
    logic [7:0] hcount;
    logic [8:0] vcount;
    logic [20:0] obs;

    int total = 0;
    int bad   = 0;
    int nclk  = 0;

    assign obs = {cep, cen, hold, int_n, hcount, vcount};

    cpu_clken #(
        .DIV(8), .LINE_T(LT), .LINES(NL), .CONT_V0(2), .CONT_H0(0),
        .INT_V(10), .INT_H(130), .INT_LEN(ILN)
    ) dut (
        .clock(clock), .reset(reset), .turbo(turbo), .cn_req(cn_req),
        .cep(cep), .cen(cen), .int_n(int_n),
        .hcount(hcount), .vcount(vcount), .hold(hold)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(negedge clock);
        nclk++;
    endtask

    function automatic int exp_h();
        return (nclk / 8) % LT;
    endfunction

    function automatic int exp_v();
        return (nclk / 8 / LT) % NL;
    endfunction

    function automatic logic exp_intn();
        int s;
        s = (nclk / 8) % FR;
        return ((s - IS + FR) % FR) >= ILN;
    endfunction

    function automatic logic exp_cont(input int h, input int v);
        return (v >= 2) && (v < 194) && (h < 128) && ((h % 8) < 6);
    endfunction

    function automatic logic ecep(input int ph, input int t);
        return (ph % (8 >> t)) == 0;
    endfunction

    function automatic logic ecen(input int ph, input int t);
        return (ph % (8 >> t)) == ((8 >> t) / 2);
    endfunction

    function automatic logic [20:0] expv(input logic a, input logic b, input logic c,
                                         input logic d, input int h, input int v);
        return {a, b, c, d, 8'(h), 9'(v)};
    endfunction

    task automatic test_reset();
        logic [20:0] e;
        int ncep, ncen;
        reset = 1'b0; turbo = 2'b00; cn_req = 1'b0;
        repeat (20) @(negedge clock);
        e = expv(1'b1, 1'b0, 1'b0, 1'b1, 0, 0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL reset_state: got %h want %h", obs, e); end
        reset = 1'b1;
        nclk = 0; ncep = 0; ncen = 0;
        for (int k = 0; k < 64; k++) begin
            e = expv(k % 8 == 0, k % 8 == 4, 1'b0, 1'b1, k / 8, 0);
            total++;
            if (obs !== e) begin bad++; $display("FAIL cadence_1x k=%0d: got %h want %h", k, obs, e); end
            if (cep) ncep++;
            if (cen) ncen++;
            tick();
        end
        total++;
        if (ncep != 8) begin bad++; $display("FAIL cep_count: got %0d want 8", ncep); end
        total++;
        if (ncen != 8) begin bad++; $display("FAIL cen_count: got %0d want 8", ncen); end
    endtask

    task automatic test_frame();
        logic [20:0] e;
        int ph, lowclk, hmax, vmax;
        lowclk = 0; hmax = 0; vmax = 0;
        for (int k = 0; k < FR * 8 + 16; k++) begin
            ph = nclk % 8;
            e = expv(ph == 0, ph == 4, 1'b0, exp_intn(), exp_h(), exp_v());
            total++;
            if (obs !== e) begin
                bad++;
                if (bad < 20) $display("FAIL frame nclk=%0d: got %h want %h", nclk, obs, e);
            end
            if (!int_n) lowclk++;
            if (int'(hcount) > hmax) hmax = int'(hcount);
            if (int'(vcount) > vmax) vmax = int'(vcount);
            tick();
        end
        total++;
        if (lowclk != ILN * 8) begin bad++; $display("FAIL int_len: got %0d clocks want %0d", lowclk, ILN * 8); end
        total++;
        if (hmax != LT - 1) begin bad++; $display("FAIL hcount_max: got %0d want %0d", hmax, LT - 1); end
        total++;
        if (vmax != NL - 1) begin bad++; $display("FAIL vcount_max: got %0d want %0d", vmax, NL - 1); end
    endtask

    task automatic test_contention();
        logic [20:0] e;
        logic eh;
        int ph;
        cn_req = 1'b1;
        repeat (8) tick();
        for (int k = 0; k < 4 * LT * 8; k++) begin
            ph = nclk % 8;
            eh = exp_cont(exp_h(), exp_v());
            e = expv(!eh && ph == 0, !eh && ph == 4, eh, exp_intn(), exp_h(), exp_v());
            total++;
            if (obs !== e) begin
                bad++;
                if (bad < 20) $display("FAIL contention nclk=%0d: got %h want %h", nclk, obs, e);
            end
            tick();
        end
        cn_req = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_entry();
        int eh[4] = '{0, 2, 5, 6};
        int ed[4] = '{6, 4, 1, 0};
        int tgt, g, held;
        for (int i = 0; i < 4; i++) begin
            tgt = (eh[i] + LT - 1) % LT;
            g = 0;
            while (!(int'(hcount) == tgt && vcount >= 9'd2 && vcount <= 9'd10 && nclk % 8 == 0)
                   && g < 2 * FR * 8) begin
                tick(); g++;
            end
            total++;
            if (g >= 2 * FR * 8) begin bad++; $display("FAIL entry_wait h=%0d: got timeout want position", eh[i]); end
            cn_req = 1'b1;
            repeat (8) tick();
            held = 0;
            for (int s = 0; s < 10; s++) begin
                if (!hold) break;
                held++;
                total++;
                if (cep !== 1'b0) begin bad++; $display("FAIL entry_cep_held: got %b want 0", cep); end
                repeat (8) tick();
            end
            cn_req = 1'b0;
            total++;
            if (held != ed[i]) begin bad++; $display("FAIL entry_delay h=%0d: got %0d want %0d", eh[i], held, ed[i]); end
            total++;
            if (cep !== 1'b1) begin bad++; $display("FAIL entry_resume h=%0d: got %b want 1", eh[i], cep); end
            total++;
            if (int'(hcount) != (eh[i] + ed[i]) % LT) begin
                bad++; $display("FAIL entry_pos: got %0d want %0d", hcount, (eh[i] + ed[i]) % LT);
            end
            repeat (8) tick();
        end
    endtask

    task automatic test_turbo();
        logic [20:0] e;
        int ph, g, t;
        cn_req = 1'b1;
        repeat (8) tick();
        g = 0;
        while (!(hcount == 8'd1 && vcount >= 9'd2 && vcount <= 9'd10 && nclk % 8 == 3) && g < 2 * FR * 8) begin
            tick(); g++;
        end
        total++;
        if (g >= 2 * FR * 8) begin bad++; $display("FAIL turbo_wait: got timeout want position"); end
        total++;
        if (hold !== 1'b1) begin bad++; $display("FAIL turbo_pre_hold: got %b want 1", hold); end
        turbo = 2'b01;
        repeat (5) tick();
        total++;
        if ({hold, cep} !== 2'b01) begin bad++; $display("FAIL turbo_hold_drop: got %b want 01", {hold, cep}); end
        cn_req = 1'b0;
        // 2x slot, then 11 requested mid-slot
        for (int k = 0; k < 8 + 3 + 13; k++) begin
            if (k == 11) turbo = 2'b11;
            ph = nclk % 8;
            t = (k < 16) ? 1 : 2;
            e = expv(ecep(ph, t), ecen(ph, t), 1'b0, exp_intn(), exp_h(), exp_v());
            total++;
            if (obs !== e) begin bad++; $display("FAIL turbo_2x_4x k=%0d: got %h want %h", k, obs, e); end
            tick();
        end
        turbo = 2'b00;
        for (int k = 0; k < 8 + 3 + 13; k++) begin
            if (k == 11) turbo = 2'b01;
            ph = nclk % 8;
            t = (k < 8) ? 2 : (k < 16) ? 0 : 1;
            e = expv(ecep(ph, t), ecen(ph, t), 1'b0, exp_intn(), exp_h(), exp_v());
            total++;
            if (obs !== e) begin bad++; $display("FAIL turbo_1x_2x k=%0d: got %h want %h", k, obs, e); end
            tick();
        end
        turbo = 2'b11;
        cn_req = 1'b1;
        repeat (8) tick();
        for (int k = 0; k < 3 * LT * 8; k++) begin
            ph = nclk % 8;
            e = expv(ecep(ph, 2), ecen(ph, 2), 1'b0, exp_intn(), exp_h(), exp_v());
            total++;
            if (obs !== e) begin
                bad++;
                if (bad < 20) $display("FAIL turbo_nocont nclk=%0d: got %h want %h", nclk, obs, e);
            end
            tick();
        end
        cn_req = 1'b0;
        turbo = 2'b00;
        repeat (8) tick();
    endtask

    task automatic test_reset_mid();
        logic [20:0] e;
        int g, ph;
        cn_req = 1'b1;
        g = 0;
        while (!(int_n == 1'b0 && hold == 1'b1) && g < 2 * FR * 8) begin
            tick(); g++;
        end
        total++;
        if (g >= 2 * FR * 8) begin bad++; $display("FAIL midreset_wait: got timeout want int_n=0 hold=1"); end
        #2 reset = 1'b0;
        #1;
        e = expv(1'b1, 1'b0, 1'b0, 1'b1, 0, 0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL midreset_async: got %h want %h", obs, e); end
        @(negedge clock);
        repeat (3) @(negedge clock);
        cn_req = 1'b0;
        reset = 1'b1;
        nclk = 0;
        for (int k = 0; k < 24; k++) begin
            ph = nclk % 8;
            e = expv(ph == 0, ph == 4, 1'b0, 1'b1, exp_h(), exp_v());
            total++;
            if (obs !== e) begin bad++; $display("FAIL midreset_restart k=%0d: got %h want %h", k, obs, e); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_contention();
        test_entry();
        test_turbo();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
